// File: rtl/arb_pkg.sv
// Shared types and widths for the cache-to-memory arbiters.
package arb_pkg;

  localparam int BLK_ADDR_W = 6;
  localparam int BLK_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    SERVE_I = 2'b01,
    SERVE_D = 2'b10,
    COOL    = 2'b11
  } arb_state_t;

  typedef enum logic {
    GNT_I = 1'b0,
    GNT_D = 1'b1
  } grant_t;

  function automatic arb_state_t serve_state(input grant_t g);
    return (g == GNT_D) ? SERVE_D : SERVE_I;
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Block-memory port: the requester (master) drives the access, the responder (slave) stalls and returns data.
interface mem_arbiter_if;
  import arb_pkg::*;

  logic                  read;
  logic                  write;
  logic [BLK_ADDR_W-1:0] address;
  logic [BLK_DATA_W-1:0] writedata;
  logic [BLK_DATA_W-1:0] readdata;
  logic                  busywait;

  modport master (output read, write, address, writedata, input readdata, busywait);
  modport slave  (input read, write, address, writedata, output readdata, busywait);

endinterface

// File: rtl/arb_rr_pick.sv
// Two-requester winner selection: round-robin against the last grant, or fixed priority to the dcache.
module arb_rr_pick
  import arb_pkg::*;
(
  input  logic   i_req,
  input  logic   d_req,
  input  grant_t last_grant,
  input  logic   mode,
  output grant_t winner
);

  // NOTE: every path assigns winner, so the block stays purely combinational with no latch.
  always_comb begin
    winner = GNT_I;
    if (i_req && d_req) begin
      if (mode) winner = GNT_D;
      else      winner = (last_grant == GNT_I) ? GNT_D : GNT_I;
    end else if (d_req) begin
      winner = GNT_D;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one block memory between the icache and dcache, one transaction at a time, with a stall watchdog.
module mem_arbiter
  import arb_pkg::*;
#(
  parameter int ARB_MODE = 0,
  parameter int TIMEOUT  = 64
) (
  input  logic          clock,
  input  logic          reset,
  mem_arbiter_if.slave  icache,
  mem_arbiter_if.slave  dcache,
  mem_arbiter_if.master mem,
  output logic          timeout_err
);

  localparam int CW = $clog2(TIMEOUT + 1);

  arb_state_t            state;
  grant_t                last_grant;
  grant_t                winner;
  logic [CW-1:0]         stall_cnt;
  logic [BLK_DATA_W-1:0] i_hold;
  logic [BLK_DATA_W-1:0] d_hold;
  logic                  i_req;
  logic                  d_req;
  logic                  serving;
  logic                  done;

  assign i_req   = icache.read;
  assign d_req   = dcache.read | dcache.write;
  assign serving = (state == SERVE_I) || (state == SERVE_D);
  assign done    = serving && (mem.read || mem.write) && !mem.busywait;

  arb_rr_pick u_pick (
    .i_req      (i_req),
    .d_req      (d_req),
    .last_grant (last_grant),
    .mode       (ARB_MODE != 0),
    .winner     (winner)
  );

  // The granted port is forwarded straight through so a dropped request reaches memory at once.
  always_comb begin
    mem.read      = 1'b0;
    mem.write     = 1'b0;
    mem.address   = '0;
    mem.writedata = '0;
    if (state == SERVE_I) begin
      mem.read    = icache.read;
      mem.address = icache.address;
    end else if (state == SERVE_D) begin
      mem.read      = dcache.read;
      mem.write     = dcache.write;
      mem.address   = dcache.address;
      mem.writedata = dcache.writedata;
    end
  end

  assign icache.busywait = i_req && !((state == SERVE_I) && !mem.busywait);
  assign dcache.busywait = d_req && !((state == SERVE_D) && !mem.busywait);
  assign icache.readdata = (state == SERVE_I) ? mem.readdata : i_hold;
  assign dcache.readdata = (state == SERVE_D) ? mem.readdata : d_hold;

  // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      last_grant  <= GNT_D;
      stall_cnt   <= '0;
      timeout_err <= 1'b0;
      i_hold      <= '0;
      d_hold      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (i_req || d_req) begin
            state      <= serve_state(winner);
            last_grant <= winner;
            stall_cnt  <= '0;
          end
        end
        SERVE_I, SERVE_D: begin
          if (done) begin
            state <= COOL;
            if (state == SERVE_I) i_hold <= mem.readdata;
            else                  d_hold <= mem.readdata;
          end else if (mem.busywait) begin
            // Saturate so a very long stall cannot wrap back below the threshold.
            if (stall_cnt != CW'(TIMEOUT)) stall_cnt <= stall_cnt + 1'b1;
            if (stall_cnt == CW'(TIMEOUT - 1)) timeout_err <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
